// File: rtl/alu_cmd_frontend.sv
// Byte-stream command front end for the ALU: collects A, B and opcode bytes,
// drives the ALU, captures its result and returns it as a byte frame.
//
// state    | meaning
// ST_RX_A  | receiving operand A bytes, LSB first
// ST_RX_B  | receiving operand B bytes, LSB first
// ST_RX_OP | receiving the opcode byte
// ST_EXEC  | operands settled, capture ALU result and flags
// ST_TX    | sending result bytes then the flag byte
module alu_cmd_frontend #(
    parameter int NB_A  = 32,
    parameter int NB_OP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [NB_A-1:0]  A,
    output logic [NB_A-1:0]  B,
    output logic [NB_OP-1:0] alu_code,
    input  logic [NB_A-1:0]  x,
    input  logic             flag_zero,
    input  logic             signo,
    output logic             busy
);

    localparam int NBY   = NB_A / 8;
    localparam int CNT_W = $clog2(NBY + 1);

    typedef enum logic [2:0] {
        ST_RX_A,
        ST_RX_B,
        ST_RX_OP,
        ST_EXEC,
        ST_TX
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [NB_A-1:0]   r_a;
    logic [NB_A-1:0]   r_b;
    logic [NB_OP-1:0]  r_code;
    logic [8*NBY-1:0]  r_res;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_rx_ready;
    logic              r_busy;

    logic              w_rx_acc;
    logic              w_tx_acc;
    logic              w_word_last;
    logic              w_tx_last;
    logic [8*NBY-1:0]  w_res_upper;

    assign w_rx_acc    = rx_valid && r_rx_ready;
    assign w_tx_acc    = r_tx_valid && tx_ready;
    assign w_word_last = (r_cnt == CNT_W'(NBY - 1));
    assign w_tx_last   = (r_cnt == CNT_W'(NBY));
    // Byte 0 of x goes straight to tx_data; only the remaining bytes need holding.
    assign w_res_upper = {6'b0, signo, flag_zero, x[NB_A-1:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RX_A;
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_code     <= '0;
            r_res      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_RX_A: begin
                    if (w_rx_acc) begin
                        for (int k = 0; k < NBY; k++) begin
                            if (r_cnt == CNT_W'(k)) r_a[8*k +: 8] <= rx_data;
                        end
                        r_busy <= 1'b1;
                        if (w_word_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_RX_B;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_RX_B: begin
                    if (w_rx_acc) begin
                        for (int k = 0; k < NBY; k++) begin
                            if (r_cnt == CNT_W'(k)) r_b[8*k +: 8] <= rx_data;
                        end
                        if (w_word_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_RX_OP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_RX_OP: begin
                    if (w_rx_acc) begin
                        r_code     <= rx_data[NB_OP-1:0];
                        r_rx_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res      <= w_res_upper;
                    r_tx_data  <= x[7:0];
                    r_tx_valid <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= ST_TX;
                end
                ST_TX: begin
                    if (w_tx_acc) begin
                        if (w_tx_last) begin
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_RX_A;
                        end else begin
                            for (int k = 1; k <= NBY; k++) begin
                                if (r_cnt == CNT_W'(k - 1)) r_tx_data <= r_res[8*(k-1) +: 8];
                            end
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_RX_A;
            endcase
        end
    end

    assign rx_ready = r_rx_ready;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign A        = r_a;
    assign B        = r_b;
    assign alu_code = r_code;
    assign busy     = r_busy;

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Scoreboard bench for alu_cmd_frontend with an adder standing in for the ALU;
// expected response bytes are queued per frame and checked by a separate monitor.
module tb_alu_cmd_frontend;

    localparam int NB_A  = 32;
    localparam int NB_OP = 4;
    localparam int NBY   = NB_A / 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [NB_A-1:0]  A;
    logic [NB_A-1:0]  B;
    logic [NB_OP-1:0] alu_code;
    logic [NB_A-1:0]  x;
    logic             flag_zero;
    logic             signo;
    logic             busy;

    alu_cmd_frontend #(.NB_A(NB_A), .NB_OP(NB_OP)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .A(A), .B(B), .alu_code(alu_code),
        .x(x), .flag_zero(flag_zero), .signo(signo), .busy(busy)
    );

    always #5 clk = ~clk;

    assign x         = A + B;
    assign flag_zero = (x == '0);
    assign signo     = x[NB_A-1];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    int         tx_idx = 0;
    bit         bp_arm = 1'b0;
    bit         rnd_tx = 1'b0;
    int         max_gap = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected byte per accepted tx byte, checks hold under stall.
    initial begin
        logic       stall;
        logic [7:0] pd;
        stall = 1'b0;
        pd    = 8'h00;
        forever begin
            @(negedge clk);
            if (stall && rst_n) begin
                check("tx_hold_valid", 64'(tx_valid), 64'd1);
                check("tx_hold_data", 64'(tx_data), 64'(pd));
            end
            if (rst_n && tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte 0x%0h expected no byte", tx_data);
                end else begin
                    check("tx_byte", 64'(tx_data), 64'(q.pop_front()));
                end
                tx_idx = (tx_idx == NBY) ? 0 : tx_idx + 1;
            end
            stall = rst_n && tx_valid && !tx_ready;
            pd    = tx_data;
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_arm && tx_idx == 2 && tx_valid) begin
                bp_arm   = 1'b0;
                tx_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk);
                    #1;
                end
                check("bp_idx_held", 64'(tx_idx), 64'd2);
                tx_ready = 1'b1;
            end else begin
                tx_ready = rnd_tx ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit first);
        int gap;
        bit acc;
        int n;
        gap = $urandom_range(0, max_gap);
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = rx_ready;
            if (acc && first) begin
                check("idle_busy", 64'(busy), 64'd0);
                check("rsp_drained", 64'(q.size()), 64'd0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL rx_timeout: byte 0x%0h not accepted, required within 300 cycles", b);
        end
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        logic [31:0] sum;
        for (int k = 0; k < NBY; k++) send_byte(a[8*k +: 8], k == 0);
        check("busy_mid", 64'(busy), 64'd1);
        for (int k = 0; k < NBY; k++) send_byte(b[8*k +: 8], 1'b0);
        send_byte(op, 1'b0);
        check("reg_A", 64'(A), 64'(a));
        check("reg_B", 64'(B), 64'(b));
        check("reg_code", 64'(alu_code), 64'(op % 16));
        check("exec_no_tx", 64'(tx_valid), 64'd0);
        sum = a + b;
        for (int k = 0; k < NBY; k++) q.push_back(sum[8*k +: 8]);
        q.push_back({6'b0, sum[31], (sum == 32'd0)});
        @(posedge clk);
        #1;
        check("tx_latency", 64'(tx_valid), 64'd1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int n;
        #2 rst_n = 1'b0;
        #10;
        check("rst_rx_ready", 64'(rx_ready), 64'd1);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_A", 64'(A), 64'd0);
        check("rst_B", 64'(B), 64'd0);
        check("rst_code", 64'(alu_code), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_frame(32'h0000_0080, 32'h0000_0080, 8'h04);
        send_frame(32'hFFFF_FFFF, 32'h0000_0001, 8'hF4);
        send_frame(32'h7FFF_FFFF, 32'h0000_0001, 8'h00);

        bp_arm = 1'b1;
        send_frame($urandom, $urandom, 8'h3C);
        n = 0;
        while (bp_arm && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_seen", 64'(bp_arm), 64'd0);

        rnd_tx = 1'b1;
        for (int i = 0; i < 24; i++) begin
            max_gap = (i % 2 == 1) ? 3 : 0;
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = -ra;
            if (i % 7 == 3) rb = 32'h8000_0000 - ra;
            send_frame(ra, rb, 8'($urandom_range(0, 255)));
        end

        // Abort a frame after three A bytes, then confirm a clean restart.
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        max_gap = 0;
        rnd_tx  = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        #2 rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("abort_rx_ready", 64'(rx_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_A", 64'(A), 64'd0);
        check("abort_tx_valid", 64'(tx_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(32'h1234_5678, 32'h0101_0101, 8'h07);

        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("final_drain", 64'(q.size()), 64'd0);
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_idle_busy", 64'(busy), 64'd0);
        check("final_tx_valid", 64'(tx_valid), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
